// File: rtl/gemm_insn_issuer.sv
// gemm_insn_issuer: packs GEMM fields into a 128-bit VTA instruction,
// queues it, and issues it to the gemm core over ap_ctrl_chain.
//
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   en                  issue enable (queue keeps filling when low)
//   in_valid/in_ready   field-bundle handshake, in_ready = !full
//   in_opcode..in_wgt_factor  instruction fields
//   in_err              one-cycle pulse: last accepted bundle dropped
//   insn, ap_start      instruction and start request to the core
//   ap_ready, ap_done   core accepted / core finished
//   ap_continue         acknowledge of ap_done while an op is active
//   busy, fifo_level    status
//   done_cnt, drop_cnt  completed (wrapping) / dropped (saturating)
module gemm_insn_issuer #(
    parameter int         INS_WIDTH   = 128,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [2:0] GEMM_OPCODE = 3'd2,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_opcode,
    input  logic [4:0]                  in_flags,
    input  logic [12:0]                 in_uop_bgn,
    input  logic [13:0]                 in_uop_end,
    input  logic [27:0]                 in_iter,
    input  logic [21:0]                 in_dst_factor,
    input  logic [21:0]                 in_src_factor,
    input  logic [19:0]                 in_wgt_factor,
    output logic                        in_err,
    output logic [INS_WIDTH-1:0]        insn,
    output logic                        ap_start,
    input  logic                        ap_ready,
    input  logic                        ap_done,
    output logic                        ap_continue,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_WIDTH-1:0]        done_cnt,
    output logic [7:0]                  drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [INS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [INS_WIDTH-1:0] packed_word;
    logic                 bundle_ok;
    logic                 full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 done_inc;

    // Bit 127 is reserved and always zero.
    assign packed_word = {1'b0, in_wgt_factor, in_src_factor,
                          in_dst_factor, in_iter, in_uop_end,
                          in_uop_bgn, in_flags, in_opcode};

    // in_iter = {iter_in, iter_out}; both must be non-zero.
    assign bundle_ok = (in_opcode == GEMM_OPCODE)
                    && (in_uop_end > {1'b0, in_uop_bgn})
                    && (in_iter[13:0] != 14'd0)
                    && (in_iter[27:14] != 14'd0);

    // Registered level only: a same-cycle pop never frees a slot.
    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && bundle_ok;

    assign ap_start    = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign ap_continue = ap_done && (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        done_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && fifo_level != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (ap_ready) begin
                    if (ap_done) begin
                        done_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (ap_done) begin
                    done_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= packed_word;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            insn       <= '0;
            in_err     <= 1'b0;
            done_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            in_err     <= accept && !bundle_ok;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                insn   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (done_inc) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (accept && !bundle_ok && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gemm_insn_issuer.sv
// Self-checking bench for gemm_insn_issuer: vector table, scoreboard
// of issued instructions, and hand-written handshake sequences.
module tb_gemm_insn_issuer;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  flags;
        logic [12:0] bgn;
        logic [13:0] uend;
        logic [13:0] it_in;
        logic [13:0] it_out;
        logic [21:0] dst;
        logic [21:0] src;
        logic [19:0] wgt;
        logic        drop;
    } vec_t;

    logic             clk;
    logic             ap_rst;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_opcode;
    logic [4:0]       in_flags;
    logic [12:0]      in_uop_bgn;
    logic [13:0]      in_uop_end;
    logic [27:0]      in_iter;
    logic [21:0]      in_dst_factor;
    logic [21:0]      in_src_factor;
    logic [19:0]      in_wgt_factor;
    logic             in_err;
    logic [127:0]     insn;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             busy;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] done_cnt;
    logic [7:0]       drop_cnt;

    logic auto_core;
    logic man_ready;
    logic man_done;

    int checks = 0;
    int errors = 0;

    logic [127:0] sb[$];
    vec_t         vecs[8];

    assign ap_ready = auto_core ? ap_start : man_ready;
    assign ap_done  = auto_core ? ap_start : man_done;

    gemm_insn_issuer #(.CNT_WIDTH(CNT_W)) dut (
        .ap_clk        (clk),
        .ap_rst        (ap_rst),
        .en            (en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_flags      (in_flags),
        .in_uop_bgn    (in_uop_bgn),
        .in_uop_end    (in_uop_end),
        .in_iter       (in_iter),
        .in_dst_factor (in_dst_factor),
        .in_src_factor (in_src_factor),
        .in_wgt_factor (in_wgt_factor),
        .in_err        (in_err),
        .insn          (insn),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .done_cnt      (done_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] golden(vec_t v);
        logic [127:0] w;
        w          = '0;
        w[2:0]     = v.op;
        w[7:3]     = v.flags;
        w[20:8]    = v.bgn;
        w[34:21]   = v.uend;
        w[48:35]   = v.it_out;
        w[62:49]   = v.it_in;
        w[84:63]   = v.dst;
        w[106:85]  = v.src;
        w[126:107] = v.wgt;
        return w;
    endfunction

    task automatic put(vec_t v);
        in_valid      = 1'b1;
        in_opcode     = v.op;
        in_flags      = v.flags;
        in_uop_bgn    = v.bgn;
        in_uop_end    = v.uend;
        in_iter       = {v.it_in, v.it_out};
        in_dst_factor = v.dst;
        in_src_factor = v.src;
        in_wgt_factor = v.wgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(int lim, string nm);
        int n = 0;
        while (!ap_start && n < lim) begin
            tick();
            n++;
        end
        chk(nm, ap_start, 1'b1);
    endtask

    task automatic wait_drain(int lim, string nm);
        int n = 0;
        while ((sb.size() != 0 || busy || fifo_level != 0) && n < lim) begin
            tick();
            n++;
        end
        chk(nm, {sb.size() != 0, busy, fifo_level}, '0);
    endtask

    // Every issue handshake must match the oldest queued expectation.
    always @(posedge clk) begin
        if (!ap_rst && ap_start && ap_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got %0h expected none", insn);
            end else begin
                chk("issue_insn", insn, sb.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        logic rdy;
        int   acc;
        int   exp_done;
        int   exp_drop;
        logic [127:0] g_single;

        vecs[0] = '{3'd2, 5'b10101, 13'd3, 14'd10, 14'd4, 14'd7,
                    22'h12345, 22'h2abcd, 20'h9876e, 1'b0};
        vecs[1] = '{3'd0, 5'd0, 13'd1, 14'd2, 14'd1, 14'd1,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[2] = '{3'd2, 5'd0, 13'd5, 14'd5, 14'd1, 14'd1,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[3] = '{3'd2, 5'd0, 13'd1, 14'd2, 14'd0, 14'd1,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[4] = '{3'd2, 5'd0, 13'd1, 14'd2, 14'd1, 14'd0,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[5] = '{3'd2, 5'd0, 13'd9, 14'd8, 14'd1, 14'd1,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[6] = '{3'd7, 5'd0, 13'd1, 14'd2, 14'd1, 14'd1,
                    22'd1, 22'd1, 20'd1, 1'b1};
        vecs[7] = '{3'd2, 5'h1f, 13'h1fff, 14'h3fff, 14'h3fff, 14'h3fff,
                    22'h3fffff, 22'h3fffff, 20'hfffff, 1'b0};

        g_single = 128'd2 | (128'd1 << 21) | (128'd1 << 35) |
                   (128'd1 << 49) | (128'd1 << 63) | (128'd1 << 85) |
                   (128'd1 << 107);

        auto_core = 1'b0;
        man_ready = 1'b0;
        man_done  = 1'b0;
        en        = 1'b1;
        ap_rst    = 1'b1;
        put(vecs[1]);
        in_valid  = 1'b0;
        repeat (2) tick();
        ap_rst = 1'b0;

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ap_start", ap_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_insn", insn, 128'd0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_done_cnt", done_cnt, '0);
        chk("rst_drop_cnt", drop_cnt, 8'd0);
        chk("rst_in_err", in_err, 1'b0);

        // Single instruction with manual core responses.
        v = '{3'd2, 5'd0, 13'd0, 14'd1, 14'd1, 14'd1,
              22'd1, 22'd1, 20'd1, 1'b0};
        put(v);
        tick();
        in_valid = 1'b0;
        sb.push_back(g_single);
        chk("single_no_start_yet", ap_start, 1'b0);
        chk("single_level", fifo_level, 3'd1);
        tick();
        chk("single_start", ap_start, 1'b1);
        chk("single_insn", insn, g_single);
        chk("single_bit127", insn[127], 1'b0);
        chk("single_busy", busy, 1'b1);
        repeat (2) tick();
        chk("single_start_held", ap_start, 1'b1);
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        chk("single_start_drop", ap_start, 1'b0);
        repeat (9) tick();
        chk("single_not_done", done_cnt, '0);
        man_done = 1'b1;
        #1;
        chk("single_continue", ap_continue, 1'b1);
        tick();
        man_done = 1'b0;
        chk("single_done_cnt", done_cnt, 8'd1);
        chk("single_idle", busy, 1'b0);

        // Fill the queue while the core never accepts.
        acc = 0;
        for (int a = 0; a < 10 && acc < 6; a++) begin
            v = vecs[0];
            v.bgn = 13'(acc);
            v.uend = 14'(acc + 1);
            v.dst = 22'(acc * 3 + 1);
            put(v);
            rdy = in_ready;
            tick();
            if (rdy) begin
                sb.push_back(golden(v));
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_level", fifo_level, 3'd4);
        chk("fill_in_ready", in_ready, 1'b0);
        chk("fill_start", ap_start, 1'b1);
        auto_core = 1'b1;
        wait_drain(60, "fill_drain");
        chk("fill_done_cnt", done_cnt, 8'd6);
        exp_done = 6;

        // Vector table: valid and malformed bundles.
        exp_drop = 0;
        for (int i = 0; i < 8; i++) begin
            put(vecs[i]);
            rdy = in_ready;
            tick();
            in_valid = 1'b0;
            chk("vec_ready", rdy, 1'b1);
            chk("vec_in_err", in_err, vecs[i].drop);
            if (vecs[i].drop) begin
                exp_drop++;
            end else begin
                sb.push_back(golden(vecs[i]));
                exp_done++;
            end
            tick();
            chk("vec_in_err_clear", in_err, 1'b0);
        end
        wait_drain(40, "vec_drain");
        chk("vec_drop_cnt", drop_cnt, 8'(exp_drop));
        chk("vec_done_cnt", done_cnt, 8'(exp_done));
        chk("vec_last_insn", insn, golden(vecs[7]));
        chk("vec_bit127", insn[127], 1'b0);

        // Drop counter saturation.
        put(vecs[1]);
        repeat (300) tick();
        in_valid = 1'b0;
        tick();
        chk("sat_drop_cnt", drop_cnt, 8'd255);
        chk("sat_level", fifo_level, 3'd0);
        chk("sat_busy", busy, 1'b0);

        // Spurious ap_done in IDLE, then same-cycle ready and done.
        auto_core = 1'b0;
        man_done  = 1'b1;
        #1;
        chk("idle_no_continue", ap_continue, 1'b0);
        tick();
        man_done = 1'b0;
        chk("idle_done_ignored", done_cnt, 8'(exp_done));
        put(vecs[0]);
        tick();
        in_valid = 1'b0;
        sb.push_back(golden(vecs[0]));
        wait_start(5, "same_start");
        man_ready = 1'b1;
        man_done  = 1'b1;
        #1;
        chk("same_continue", ap_continue, 1'b1);
        tick();
        man_ready = 1'b0;
        man_done  = 1'b0;
        exp_done++;
        chk("same_idle", busy, 1'b0);
        chk("same_done_cnt", done_cnt, 8'(exp_done));

        // en low holds the queue; reset while BUSY abandons everything.
        en = 1'b0;
        put(vecs[0]);
        tick();
        tick();
        in_valid = 1'b0;
        sb.push_back(golden(vecs[0]));
        sb.push_back(golden(vecs[0]));
        repeat (5) tick();
        chk("en_hold_start", ap_start, 1'b0);
        chk("en_hold_level", fifo_level, 3'd2);
        en = 1'b1;
        wait_start(5, "en_resume_start");
        chk("en_resume_level", fifo_level, 3'd1);
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        chk("busy_state", busy, 1'b1);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        sb.delete();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_start", ap_start, 1'b0);
        chk("mid_rst_level", fifo_level, 3'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_insn", insn, 128'd0);
        chk("mid_rst_done_cnt", done_cnt, '0);
        chk("mid_rst_drop_cnt", drop_cnt, 8'd0);
        repeat (3) tick();
        chk("mid_rst_no_issue", ap_start, 1'b0);

        // done_cnt wrap at all-ones.
        auto_core = 1'b1;
        acc = 0;
        put(vecs[0]);
        for (int c = 0; c < 2000 && acc < 255; c++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                sb.push_back(golden(vecs[0]));
                acc++;
            end
        end
        in_valid = 1'b0;
        wait_drain(1000, "wrap_drain");
        chk("wrap_all_ones", done_cnt, 8'hFF);
        put(vecs[0]);
        tick();
        in_valid = 1'b0;
        sb.push_back(golden(vecs[0]));
        wait_drain(20, "wrap_drain_last");
        chk("wrap_zero", done_cnt, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_insn_issuer.md
Name: gemm_insn_issuer

Overview:
Instruction-side front end for the gemm core: packs host-supplied GEMM fields into the 128-bit VTA instruction word (encoder counterpart of the core's decoder) and issues them one at a time over the core's ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue). A small FIFO decouples the field producer from core execution. Malformed instructions are dropped and counted. Sits between the command source and the gemm core's insn/ap_* ports.

Parameters:
INS_WIDTH, 128, instruction word width (layout fixed for 128)
FIFO_DEPTH, 4, instruction queue depth, power of two, >=2
GEMM_OPCODE, 3'd2, only opcode accepted for issue
CNT_WIDTH, 16, done counter width

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  synchronous active-high reset
en  in  1  issue enable; 0 = no new issue (queue still fills)
in_valid  in  1  field bundle valid
in_ready  out  1  queue can accept (= !full, registered state only)
in_opcode  in  3  opcode
in_flags  in  5  {reset_reg,push_next,push_prev,pop_next,pop_prev} -> insn[7:3]
in_uop_bgn  in  13  -> insn[20:8]
in_uop_end  in  14  -> insn[34:21]
in_iter  in  28  {iter_in,iter_out} -> insn[62:35]
in_dst_factor  in  22  {in,out} -> insn[84:63]
in_src_factor  in  22  {in,out} -> insn[106:85]
in_wgt_factor  in  20  {in,out} -> insn[126:107]
in_err  out  1  one-cycle pulse: last accepted bundle dropped
insn  out  INS_WIDTH  instruction to core
ap_start  out  1  start request to core
ap_ready  in  1  core accepted insn
ap_done  in  1  core finished
ap_continue  out  1  ack of ap_done
busy  out  1  state != IDLE
fifo_level  out  clog2(FIFO_DEPTH)+1  queued entries
done_cnt  out  CNT_WIDTH  completed instructions, wraps
drop_cnt  out  8  dropped bundles, saturates at 255

Behaviour:
- Packing: insn[2:0]=opcode, fields per Ports, insn[127]=0 always.
- Accept: in_valid && in_ready at edge. Bundle dropped (not queued, in_err=1 next cycle, drop_cnt++ saturating) if opcode != GEMM_OPCODE or uop_end <= uop_bgn or iter_out==0 or iter_in==0. Dropped bundles still consume the handshake.
- in_ready depends only on fifo_level; a pop in the same cycle does not open a slot for a push into a full queue.
- FSM IDLE/START/BUSY:
  IDLE: if en && fifo_level!=0 at edge -> pop head into insn register, ap_start=1, -> START.
  START: ap_start held 1, insn stable, until ap_ready sampled 1; then ap_start=0 -> BUSY, or -> IDLE if ap_done also 1 that cycle (count it).
  BUSY: wait ap_done; on it done_cnt++, -> IDLE.
- ap_continue = ap_done && state!=IDLE (combinational); ap_done in IDLE is ignored and not counted.
- Latency: bundle accepted at edge N into empty queue, IDLE, en=1 -> ap_start high after edge N+1. Back-to-back: ap_done at edge M -> next ap_start after edge M+1 (one IDLE cycle minimum).
- insn holds last issued value until next pop; en=0 mid-op does not abort START/BUSY.
- Reset (any time, incl. mid-op): queue emptied, state IDLE, insn=0, ap_start=0, in_err=0, done_cnt=0, drop_cnt=0, fifo_level=0, in_ready=1 next cycle. Core shares ap_rst; in-flight op abandoned.
- done_cnt wraps 2^CNT_WIDTH-1 -> 0.

Test Plan:
- Single insn: opcode=2, uop_bgn=0, uop_end=1, iter=1/1, factors=1 -> insn==packed golden, insn[127]=0; ap_start 2 cycles after accept; ap_ready after 3 cycles, ap_done 10 later -> done_cnt=1, busy=0.
- Fill: ap_ready held 0, push 6 bundles -> 4 queued + 1 in START, in_ready=0, fifo_level=4; release -> 5 issues in order, done_cnt=5.
- Drops: opcode=0; uop_end=uop_bgn=5; iter_in=0 -> in_err pulses x3, drop_cnt=3, no ap_start; 300 drops -> drop_cnt=255.
- Same-cycle ap_ready&ap_done -> START->IDLE, done_cnt+1, ap_continue=1 that cycle; spurious ap_done in IDLE -> no count.
- en=0 with 2 queued -> ap_start stays 0; en=1 -> issue resumes; ap_rst asserted in BUSY -> all outputs reset values, queued entries lost.
- done_cnt at 0xFFFF plus one completion -> 0x0000.
